matmul_input_loader: RTL

//  Reads the weight and input operand matrices from RAM, one row per access, and holds them as flat buses for the matmul FSM.
//  It is the read-side counterpart of the output write-back path and uses the same memory timing (fixed access latency, row-wide port).

---
 rtl/matmul_mem_pkg.sv | 25 ++
 rtl/matmul_input_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/matmul_mem_pkg.sv
// Shared memory map and state/selection types for the matmul RAM read and write-back paths.
`ifndef MATMUL_MEM_DEFS
`define MATMUL_MEM_DEFS
`define WEIGHT_MAT_BASE_ADDR 32'h0000_1000
`define INPUT_MAT_BASE_ADDR  32'h0000_2000
`define OUTPUT_MAT_BASE_ADDR 32'h0000_3000
`define MEM_ADDR_INCR        32'd8
`define MEM_PORT_WIDTH       64
`endif

package matmul_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ld_state_t;

  typedef enum logic {
    WEIGHT,
    INPUT
  } mat_sel_t;

endpackage

// File: rtl/matmul_input_loader.sv
// Loads the weight then input matrix from RAM one row per access and presents
// both as flat buses; load_done pulses once both are captured.
module matmul_input_loader
  import matmul_mem_pkg::*;
#(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int WORD_SIZE          = 16,
  parameter int MEM_ACCESS_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            fsm_rdy,
  input  logic                            stall,
  output logic [31:0]                     mem_addr,
  output logic                            mem_rd_en,
  input  logic [COLS*WORD_SIZE-1:0]       mem_rd_data,
  output logic                            load_rdy,
  output logic                            load_done,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  weight_mat,
  output logic [ROWS*COLS*WORD_SIZE-1:0]  input_mat
);

  localparam int ROW_W  = COLS * WORD_SIZE;
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DLY_W  = $clog2(MEM_ACCESS_LATENCY + 1);

  ld_state_t           state_q, state_d;
  mat_sel_t            sel_q, sel_d;
  logic [RIDX_W-1:0]   row_idx_q, row_idx_d;
  logic [DLY_W-1:0]    delay_q, delay_d;
  logic [31:0]         addr_d;
  logic                rd_en_d;
  logic                done_d;
  logic                capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= WEIGHT;
      row_idx_q <= '0;
      delay_q   <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      row_idx_q <= row_idx_d;
      delay_q   <= delay_d;
      mem_addr  <= addr_d;
      mem_rd_en <= rd_en_d;
      load_done <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    row_idx_d = row_idx_q;
    delay_d   = delay_q;
    addr_d    = mem_addr;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && fsm_rdy) begin
          row_idx_d = '0;
          sel_d     = WEIGHT;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          addr_d  = ((sel_q == WEIGHT) ? `WEIGHT_MAT_BASE_ADDR : `INPUT_MAT_BASE_ADDR)
                    + 32'(row_idx_q) * `MEM_ADDR_INCR;
          rd_en_d = 1'b1;
          delay_d = DLY_W'(MEM_ACCESS_LATENCY - 1);
          state_d = WAIT;
        end
      end
      // RAM latency is fixed, so WAIT counts down regardless of stall
      WAIT: begin
        if (delay_q == '0) begin
          capture = 1'b1;
          if (row_idx_q != RIDX_W'(ROWS - 1)) begin
            row_idx_d = row_idx_q + RIDX_W'(1);
            state_d   = ISSUE;
          end else if (sel_q == WEIGHT) begin
            sel_d     = INPUT;
            row_idx_d = '0;
            state_d   = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          delay_d = delay_q - DLY_W'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_rdy = (state_q == IDLE);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_W-1:0] w_row, i_row;

    always_ff @(posedge clk) begin
      if (rst) begin
        w_row <= '0;
        i_row <= '0;
      end else if (capture && (row_idx_q == RIDX_W'(r))) begin
        if (sel_q == WEIGHT) w_row <= mem_rd_data;
        else                 i_row <= mem_rd_data;
      end
    end

    assign weight_mat[r*ROW_W +: ROW_W] = w_row;
    assign input_mat[r*ROW_W +: ROW_W]  = i_row;
  end

endmodule
